// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/execute control sequencer
// Every port is a flop; outputs are decoded from the next state and registered.
module instr_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [3:0]       op_code,
  input  logic             alu_str,
  input  logic             mov_str,
  input  logic             ldsr_str,
  input  logic             mem_ack,
  output logic             if_stb,
  output logic             ir_ld,
  output logic             pc_inc,
  output logic             iri_en,
  output logic             irj_en,
  output logic             brj_en,
  output logic             rf_rd,
  output logic             rf_wr,
  output logic             alu_a_ld,
  output logic             alu_b_ld,
  output logic             alu_out_en,
  output logic             tmp_ld,
  output logic             tmp_out_en,
  output logic             mar_ld,
  output logic             mdr_out_en,
  output logic             mem_req,
  output logic             mem_we,
  output logic             busy,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_IR_LOAD, S_DECODE,
    S_ALU_A, S_ALU_B, S_ALU_WB,
    S_MOV_SRC, S_MOV_WB,
    S_LS_ADDR, S_LS_MEM, S_LS_WB,
    S_FAULT
  } state_t;

  typedef struct packed {
    logic if_stb, ir_ld, pc_inc, iri_en, irj_en, brj_en, rf_rd, rf_wr;
    logic alu_a_ld, alu_b_ld, alu_out_en, tmp_ld, tmp_out_en;
    logic mar_ld, mdr_out_en, mem_req, mem_we, busy, fault;
  } ctl_t;

  localparam logic [3:0] OP_NOT   = 4'd2;
  localparam logic [3:0] OP_ADDI  = 4'd7;
  localparam logic [3:0] OP_SUBI  = 4'd8;
  localparam logic [3:0] OP_MOVI  = 4'd9;
  localparam logic [3:0] OP_STORE = 4'd12;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state, next_state;
  ctl_t       ctl, ctl_next;
  logic [7:0] wait_cnt;
  logic [1:0] code_next;
  logic       retire;
  logic       wait_expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      ctl        <= '0;
      fault_code <= 2'b00;
      retired    <= '0;
      wait_cnt   <= '0;
    end else begin
      state      <= next_state;
      ctl        <= ctl_next;
      fault_code <= code_next;
      if (retire)
        retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
      if ((next_state == S_FETCH || next_state == S_LS_MEM) && next_state != state)
        wait_cnt <= '0;
      else if ((state == S_FETCH || state == S_LS_MEM) && !mem_ack)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // An ack in the cycle the count would expire takes priority over the timeout.
  always_comb begin
    next_state   = state;
    code_next    = fault_code;
    retire       = 1'b0;
    wait_expired = !mem_ack && (wait_cnt == WAIT_LAST);
    case (state)
      S_IDLE:    if (run) next_state = S_FETCH;
      S_FETCH: begin
        if (mem_ack) begin
          next_state = S_IR_LOAD;
        end else if (wait_expired) begin
          next_state = S_FAULT;
          code_next  = 2'b10;
        end
      end
      S_IR_LOAD: next_state = S_DECODE;
      S_DECODE: begin
        if (alu_str)       next_state = S_ALU_A;
        else if (mov_str)  next_state = S_MOV_SRC;
        else if (ldsr_str) next_state = S_LS_ADDR;
        else begin
          next_state = S_FAULT;
          code_next  = 2'b01;
        end
      end
      S_ALU_A:   next_state = (op_code == OP_NOT) ? S_ALU_WB : S_ALU_B;
      S_ALU_B:   next_state = S_ALU_WB;
      S_MOV_SRC: next_state = S_MOV_WB;
      S_LS_ADDR: next_state = S_LS_MEM;
      S_LS_MEM: begin
        if (mem_ack) begin
          if (op_code == OP_STORE) begin
            retire     = 1'b1;
            next_state = run ? S_FETCH : S_IDLE;
          end else begin
            next_state = S_LS_WB;
          end
        end else if (wait_expired) begin
          next_state = S_FAULT;
          code_next  = 2'b10;
        end
      end
      S_ALU_WB, S_MOV_WB, S_LS_WB: begin
        retire     = 1'b1;
        next_state = run ? S_FETCH : S_IDLE;
      end
      S_FAULT:   next_state = S_FAULT;
      default:   next_state = S_IDLE;
    endcase
  end

  // Control word for the state about to be entered, so the flops hold it for that whole state.
  always_comb begin
    ctl_next = '0;
    case (next_state)
      S_FETCH:   begin ctl_next.if_stb = 1'b1; ctl_next.mem_req = 1'b1; end
      S_IR_LOAD: begin ctl_next.ir_ld = 1'b1; ctl_next.pc_inc = 1'b1; end
      S_ALU_A:   begin ctl_next.iri_en = 1'b1; ctl_next.rf_rd = 1'b1; ctl_next.alu_a_ld = 1'b1; end
      S_ALU_B: begin
        ctl_next.alu_b_ld = 1'b1;
        if (op_code == OP_ADDI || op_code == OP_SUBI) begin
          ctl_next.brj_en = 1'b1;
        end else begin
          ctl_next.irj_en = 1'b1;
          ctl_next.rf_rd  = 1'b1;
        end
      end
      S_ALU_WB:  begin ctl_next.iri_en = 1'b1; ctl_next.alu_out_en = 1'b1; ctl_next.rf_wr = 1'b1; end
      S_MOV_SRC: begin
        ctl_next.tmp_ld = 1'b1;
        if (op_code == OP_MOVI) begin
          ctl_next.brj_en = 1'b1;
        end else begin
          ctl_next.irj_en = 1'b1;
          ctl_next.rf_rd  = 1'b1;
        end
      end
      S_MOV_WB:  begin ctl_next.iri_en = 1'b1; ctl_next.tmp_out_en = 1'b1; ctl_next.rf_wr = 1'b1; end
      S_LS_ADDR: begin ctl_next.irj_en = 1'b1; ctl_next.rf_rd = 1'b1; ctl_next.mar_ld = 1'b1; end
      S_LS_MEM: begin
        ctl_next.mem_req = 1'b1;
        if (op_code == OP_STORE) begin
          ctl_next.iri_en = 1'b1;
          ctl_next.rf_rd  = 1'b1;
          ctl_next.mem_we = 1'b1;
        end
      end
      S_LS_WB:   begin ctl_next.iri_en = 1'b1; ctl_next.mdr_out_en = 1'b1; ctl_next.rf_wr = 1'b1; end
      S_FAULT:   ctl_next.fault = 1'b1;
      default:   ctl_next = '0;
    endcase
    ctl_next.busy = (next_state != S_IDLE) && (next_state != S_FAULT);
  end

  assign if_stb     = ctl.if_stb;
  assign ir_ld      = ctl.ir_ld;
  assign pc_inc     = ctl.pc_inc;
  assign iri_en     = ctl.iri_en;
  assign irj_en     = ctl.irj_en;
  assign brj_en     = ctl.brj_en;
  assign rf_rd      = ctl.rf_rd;
  assign rf_wr      = ctl.rf_wr;
  assign alu_a_ld   = ctl.alu_a_ld;
  assign alu_b_ld   = ctl.alu_b_ld;
  assign alu_out_en = ctl.alu_out_en;
  assign tmp_ld     = ctl.tmp_ld;
  assign tmp_out_en = ctl.tmp_out_en;
  assign mar_ld     = ctl.mar_ld;
  assign mdr_out_en = ctl.mdr_out_en;
  assign mem_req    = ctl.mem_req;
  assign mem_we     = ctl.mem_we;
  assign busy       = ctl.busy;
  assign fault      = ctl.fault;

endmodule
